aludec_mc: RTL and testbench

Registered, multi-cycle-aware ALU control decoder for the MIPS datapath. Each cycle it accepts an `aluop`/`funct` pair through a valid/ready handshake and presents a registered ALU control word. The control word is wider than the 3-bit encoding and covers shifts, NOR and a HI/LO multiply/divide path. Multiply and divide hold the decoder busy for a parametrised number of cycles, and the output register supports back-pressure from the execute stage.

---
 rtl/aludec_mc_if.sv | 27 ++
 rtl/aludec_mc.sv | 175 +++++++++++++++++
 tb/tb_aludec_mc.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aludec_mc_if.sv
// aludec_mc_if: handshake bundle between the issue side and the ALU control decoder.
//   master : drives in_valid/aluop/funct and out_ready; sees in_ready and the outputs.
//   slave  : the decoder; drives in_ready, out_valid, alu_ctrl, illegal, busy.
// Parameter CTRL_W must match the decoder's CTRL_W.
interface aludec_mc_if #(
    parameter int unsigned CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        aluop;
    logic [5:0]        funct;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal;
    logic              busy;

    modport master (
        output in_valid, aluop, funct, out_ready,
        input  in_ready, out_valid, alu_ctrl, illegal, busy
    );

    modport slave (
        input  in_valid, aluop, funct, out_ready,
        output in_ready, out_valid, alu_ctrl, illegal, busy
    );
endinterface

// File: rtl/aludec_mc.sv
// aludec_mc: registered ALU control decoder with valid/ready handshake and an optional
// multi-cycle HI/LO (mult/div) busy path.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : aludec_mc_if.slave (in_valid/in_ready/aluop/funct in, out_valid/out_ready/
//           alu_ctrl/illegal/busy out)
// Build option: define ALUDEC_MULDIV_EN to decode mult/div through the BUSY path; otherwise
// they decode as illegal, and the FSM and counter are not built (busy tied low).
module aludec_mc #(
    parameter int unsigned CTRL_W      = 4,
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 8
) (
    input logic        clk,
    input logic        rst_n,
    aludec_mc_if.slave bus
);

    localparam bit PARAMS_OK = (CTRL_W >= 4) && (MULT_CYCLES >= 1) && (DIV_CYCLES >= 1);

    if (!PARAMS_OK) begin : g_param_check
        $error("aludec_mc: CTRL_W must be >= 4, MULT_CYCLES and DIV_CYCLES >= 1");
    end

    logic [3:0]        dec_code;
    logic              dec_illegal;
    logic              accept;
    logic              idle;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic              illegal_q, illegal_d;

`ifdef ALUDEC_MULDIV_EN
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [3:0]       pend_q, pend_d;  // code emitted when the multi-cycle op completes
    logic             dec_mult, dec_div;
`endif

    // Combinational decode of the presented aluop/funct pair.
    always_comb begin
        dec_code    = 4'b1111;
        dec_illegal = 1'b0;
`ifdef ALUDEC_MULDIV_EN
        dec_mult    = 1'b0;
        dec_div     = 1'b0;
`endif
        case (bus.aluop)
            2'b00: dec_code = 4'b0010;
            2'b01: dec_code = 4'b0110;
            2'b11: dec_code = 4'b0001;
            default: begin
                case (bus.funct)
                    6'b100000: dec_code = 4'b0010;
                    6'b100010: dec_code = 4'b0110;
                    6'b100100: dec_code = 4'b0000;
                    6'b100101: dec_code = 4'b0001;
                    6'b101010: dec_code = 4'b0111;
                    6'b100111: dec_code = 4'b1100;
                    6'b000000: dec_code = 4'b1000;
                    6'b000010: dec_code = 4'b1001;
`ifdef ALUDEC_MULDIV_EN
                    6'b011000: begin
                        dec_code = 4'b1010;
                        dec_mult = 1'b1;
                    end
                    6'b011010: begin
                        dec_code = 4'b1011;
                        dec_div  = 1'b1;
                    end
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

`ifdef ALUDEC_MULDIV_EN
    assign idle     = (state_q == StIdle);
    assign bus.busy = busy_q;
`else
    assign idle     = 1'b1;
    assign bus.busy = 1'b0;
`endif

    assign bus.in_ready  = rst_n && idle && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.illegal   = illegal_q;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_ctrl_d  = alu_ctrl_q;
        illegal_d   = illegal_q;
        // Consumption; a reload below overrides it for back-to-back transfers.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
`ifdef ALUDEC_MULDIV_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (dec_mult || dec_div) begin
                        pend_d  = dec_code;
                        cnt_d   = dec_mult ? MULT_LOAD : DIV_LOAD;
                        busy_d  = 1'b1;
                        state_d = StBusy;
                    end else begin
                        alu_ctrl_d  = CTRL_W'(dec_code);
                        illegal_d   = dec_illegal;
                        out_valid_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!out_valid_q || bus.out_ready) begin
                    alu_ctrl_d  = CTRL_W'(pend_q);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`else
        if (accept) begin
            alu_ctrl_d  = CTRL_W'(dec_code);
            illegal_d   = dec_illegal;
            out_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_ctrl_q  <= '0;
            illegal_q   <= 1'b0;
`ifdef ALUDEC_MULDIV_EN
            state_q     <= StIdle;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            pend_q      <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            alu_ctrl_q  <= alu_ctrl_d;
            illegal_q   <= illegal_d;
`ifdef ALUDEC_MULDIV_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_aludec_mc.sv
// tb_aludec_mc: directed, self-checking bench for aludec_mc (CTRL_W=4, MULT_CYCLES=4,
// DIV_CYCLES=8). Expectations follow ALUDEC_MULDIV_EN when it is defined.
module tb_aludec_mc;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    aludec_mc_if #(.CTRL_W(4)) bus ();

    aludec_mc #(
        .CTRL_W      (4),
        .MULT_CYCLES (4),
        .DIV_CYCLES  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn);
        bus.in_valid = v;
        bus.aluop    = op;
        bus.funct    = fn;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ov"},  32'(bus.out_valid), 32'd0);
        check({tag, "_ctl"}, 32'(bus.alu_ctrl),  32'd0);
        check({tag, "_ill"}, 32'(bus.illegal),   32'd0);
        check({tag, "_bsy"}, 32'(bus.busy),      32'd0);
    endtask

    logic [1:0] s_op  [11];
    logic [5:0] s_fn  [11];
    logic [3:0] s_exp [11];
    int         seen_ov;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 2'b00, 6'd0);

        s_op = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        s_fn = '{6'd0, 6'd0, 6'd0, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd2};
        s_exp = '{4'd2, 4'd6, 4'd1, 4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd12, 4'd8, 4'd9};

        // Reset state.
        @(negedge clk);
        step();
        check_idle_outputs("rst");
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);

        // Stream of single-cycle ops, one per clock.
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, s_op[i], s_fn[i]);
            #1;
            check($sformatf("strm%0d_rdy", i), 32'(bus.in_ready), 32'd1);
            step();
            check($sformatf("strm%0d_ov", i),  32'(bus.out_valid), 32'd1);
            check($sformatf("strm%0d_ctl", i), 32'(bus.alu_ctrl),  32'(s_exp[i]));
            check($sformatf("strm%0d_ill", i), 32'(bus.illegal),   32'd0);
        end
        drive(1'b0, 2'b00, 6'd0);
        step();
        check("strm_drain_ov", 32'(bus.out_valid), 32'd0);

        // Unsupported funct.
        drive(1'b1, 2'b10, 6'd63);
        step();
        drive(1'b0, 2'b00, 6'd0);
        check("ill63_ov",  32'(bus.out_valid), 32'd1);
        check("ill63_ctl", 32'(bus.alu_ctrl),  32'd15);
        check("ill63_ill", 32'(bus.illegal),   32'd1);
        check("ill63_bsy", 32'(bus.busy),      32'd0);
        step();

`ifdef ALUDEC_MULDIV_EN
        // mult: busy for 4 cycles, result 4 edges after the accept edge.
        drive(1'b1, 2'b10, 6'd24);
        step();
        drive(1'b0, 2'b00, 6'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mult%0d_bsy", k), 32'(bus.busy),      32'd1);
            check($sformatf("mult%0d_rdy", k), 32'(bus.in_ready),  32'd0);
            check($sformatf("mult%0d_ov", k),  32'(bus.out_valid), 32'd0);
            step();
        end
        check("mult_ov",  32'(bus.out_valid), 32'd1);
        check("mult_ctl", 32'(bus.alu_ctrl),  32'd10);
        check("mult_bsy", 32'(bus.busy),      32'd0);
        step();

        // div: 8 edges.
        drive(1'b1, 2'b10, 6'd26);
        step();
        drive(1'b0, 2'b00, 6'd0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("div%0d_bsy", k), 32'(bus.busy),      32'd1);
            check($sformatf("div%0d_ov", k),  32'(bus.out_valid), 32'd0);
            step();
        end
        check("div_ov",  32'(bus.out_valid), 32'd1);
        check("div_ctl", 32'(bus.alu_ctrl),  32'd11);
        check("div_bsy", 32'(bus.busy),      32'd0);
        step();
`else
        // Without the mult/div path, funct 24 and 26 are illegal single-cycle ops.
        drive(1'b1, 2'b10, 6'd24);
        step();
        check("mult_ov",  32'(bus.out_valid), 32'd1);
        check("mult_ctl", 32'(bus.alu_ctrl),  32'd15);
        check("mult_ill", 32'(bus.illegal),   32'd1);
        check("mult_bsy", 32'(bus.busy),      32'd0);
        drive(1'b1, 2'b10, 6'd26);
        step();
        drive(1'b0, 2'b00, 6'd0);
        check("div_ctl", 32'(bus.alu_ctrl), 32'd15);
        check("div_ill", 32'(bus.illegal),  32'd1);
        check("div_bsy", 32'(bus.busy),     32'd0);
        step();
`endif

        // Back-pressure: output held while out_ready is low, pending op not accepted.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b10, 6'd36);
        step();
        drive(1'b1, 2'b01, 6'd0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_ov", k),  32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d_ctl", k), 32'(bus.alu_ctrl),  32'd0);
            check($sformatf("bp%0d_rdy", k), 32'(bus.in_ready),  32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b0, 2'b00, 6'd0);
        check("bp_next_ov",  32'(bus.out_valid), 32'd1);
        check("bp_next_ctl", 32'(bus.alu_ctrl),  32'd6);
        step();
        check("bp_done_ov", 32'(bus.out_valid), 32'd0);

`ifdef ALUDEC_MULDIV_EN
        // Reset at cnt == 2 of a div drops it.
        drive(1'b1, 2'b10, 6'd26);
        step();
        drive(1'b0, 2'b00, 6'd0);
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        step();
        check_idle_outputs("abrt");
        check("abrt_rdy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
`else
        // Reset while a result is held under back-pressure drops it.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b01, 6'd0);
        step();
        drive(1'b0, 2'b00, 6'd0);
        check("abrt_pre_ov", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        check_idle_outputs("abrt");
        check("abrt_rdy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
`endif
        seen_ov = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid) seen_ov++;
            step();
        end
        check("abrt_no_ov", 32'(seen_ov), 32'd0);

        // Fresh add after the abort.
        drive(1'b1, 2'b00, 6'd0);
        #1;
        check("post_rdy", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b0, 2'b00, 6'd0);
        check("post_ov",  32'(bus.out_valid), 32'd1);
        check("post_ctl", 32'(bus.alu_ctrl),  32'd2);
        check("post_ill", 32'(bus.illegal),   32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
